// File: rtl/mem_bus.sv
// -----------------------------------------------------------------------------
// mem_bus -- single-master memory bus with RAM, GPIO, free-running cycle
// counter and an optional UART transmitter behind a 4-entry byte FIFO.
//
// Configuration macro:
//   MEM_BUS_UART_EN  defined   -> UART FIFO + transmitter at 0xFF0002
//                    undefined -> 0xFF0002 is unmapped, uart_tx tied high
//
// Parameters:
//   RAM_WORDS  number of 32-bit RAM words (power of two, <= 2^20)
//   UART_DIV   clock cycles per UART bit
//
// Ports:
//   clk          system clock, rising edge
//   nreset       asynchronous active-low reset
//   address_bus  24-bit word address
//   control_bus  {ram_read, ram_write}; 2'b11 is an illegal request
//   wdata_bus    write data
//   rdata_bus    combinational read data (0 unless a plain read)
//   gpio_out     8-bit output port
//   uart_tx      serial transmit line, idle high
//   bus_err      sticky error flag, cleared only by reset
//
// Address map (word addresses):
//   0x000000 .. RAM_WORDS-1  RAM
//   0xFF0000                 GPIO   (read {24'b0, gpio_out})
//   0xFF0001                 CYCLE  (32-bit counter, write loads)
//   0xFF0002                 UART   (write pushes byte, read returns status
//                                    {27'b0, full, count[2:0], busy})
// -----------------------------------------------------------------------------
module mem_bus #(
    parameter int RAM_WORDS = 4096,
    parameter int UART_DIV  = 434
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [23:0] address_bus,
    input  logic [1:0]  control_bus,
    input  logic [31:0] wdata_bus,
    output logic [31:0] rdata_bus,
    output logic [7:0]  gpio_out,
    output logic        uart_tx,
    output logic        bus_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [23:0] ADDR_GPIO = 24'hFF0000;
    localparam logic [23:0] ADDR_CYC  = 24'hFF0001;
    localparam logic [23:0] ADDR_UART = 24'hFF0002;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_rd;
    logic        w_wr;
    logic        w_both;
    logic        w_ram_sel;
    logic        w_gpio_sel;
    logic        w_cyc_sel;
    logic        w_uart_sel;
    logic        w_mapped;
    logic        w_push_drop;
    logic [31:0] w_uart_status;

    assign w_rd       = (control_bus == 2'b10);
    assign w_wr       = (control_bus == 2'b01);
    assign w_both     = (control_bus == 2'b11);
    assign w_ram_sel  = (address_bus[23:AW] == '0);
    assign w_gpio_sel = (address_bus == ADDR_GPIO);
    assign w_cyc_sel  = (address_bus == ADDR_CYC);
    assign w_mapped   = w_ram_sel | w_gpio_sel | w_cyc_sel | w_uart_sel;

    // ------------------------------------------------------------------
    // Storage and core registers
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];
    logic [7:0]  r_gpio;
    logic [31:0] r_cycle;
    logic        r_bus_err;

    // NOTE: memory arrays carry no reset so they map onto RAM resources;
    // software must initialise any word it reads.
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_sel) begin
            r_ram[address_bus[AW-1:0]] <= wdata_bus;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_gpio    <= 8'd0;
            r_cycle   <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_wr && w_gpio_sel) begin
                r_gpio <= wdata_bus[7:0];
            end
            // A bus write wins over the free-running increment.
            if (w_wr && w_cyc_sel) begin
                r_cycle <= wdata_bus;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_both || ((w_rd || w_wr) && !w_mapped) || w_push_drop) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign gpio_out = r_gpio;
    assign bus_err  = r_bus_err;

    // ------------------------------------------------------------------
    // Read mux (combinational, zero latency)
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        rdata_bus = 32'd0;
        if (w_rd) begin
            if (w_ram_sel) begin
                rdata_bus = r_ram[address_bus[AW-1:0]];
            end else if (w_gpio_sel) begin
                rdata_bus = {24'd0, r_gpio};
            end else if (w_cyc_sel) begin
                rdata_bus = r_cycle;
            end else if (w_uart_sel) begin
                rdata_bus = w_uart_status;
            end
        end
    end

`ifdef MEM_BUS_UART_EN
    // ------------------------------------------------------------------
    // UART: 4-entry FIFO feeding an 8N1 transmitter
    // ------------------------------------------------------------------
    localparam int BW = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    logic [7:0]  r_fifo [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    tx_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shreg;
    logic        r_tx;

    logic        w_full;
    logic        w_empty;
    logic        w_baud_end;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;

    assign w_uart_sel = (address_bus == ADDR_UART);
    assign w_full     = (r_count == 3'd4);
    assign w_empty    = (r_count == 3'd0);
    assign w_baud_end = (r_baud == BW'(UART_DIV - 1));

    // A byte leaves the FIFO exactly when the transmitter starts a frame:
    // from IDLE immediately, or at the end of STOP for back-to-back frames.
    assign w_pop = !w_empty &&
                   ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_baud_end));

    // A pop in the same cycle frees a slot, so a push to a full FIFO is
    // accepted in that case.
    assign w_push_req  = w_wr && w_uart_sel;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_push_drop = w_push_req && !w_push;

    assign w_uart_status = {27'd0, w_full, r_count, (r_state != TX_IDLE)};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= wdata_bus[7:0];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmitter FSM; uart_tx is registered so the line is glitch-free.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shreg <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_state <= TX_START;
                        r_shreg <= r_fifo[r_rd_ptr];
                        r_tx    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_baud_end) begin
                        r_state <= TX_DATA;
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shreg[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                TX_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // LSB first: shift and present the next bit.
                            r_bit   <= r_bit + 3'd1;
                            r_shreg <= {1'b0, r_shreg[7:1]};
                            r_tx    <= r_shreg[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                TX_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_state <= TX_START;
                            r_shreg <= r_fifo[r_rd_ptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = r_tx;
`else
    // UART not built: its address decodes as unmapped and the line idles.
    logic w_unused_div;

    assign w_unused_div  = (UART_DIV != 0);
    assign w_uart_sel    = 1'b0;
    assign w_push_drop   = 1'b0;
    assign w_uart_status = 32'd0;
    assign uart_tx       = 1'b1;
`endif

endmodule
